game_controller: RTL
====================

Name: game_controller

Overview:
- Sequential game controller placed directly upstream of the move checker (check_move).
- Owns the committed 18-bit board and the game state, and tracks whose turn it is.
- Turns each player move request into a candidate next_move and drives turn, state, curr_move and next_move into the checker.
- Consumes the checker's valid_move verdict, commits or rejects the move, then evaluates win/draw.

Parameters:
FIRST_PLAYER, 2'b01, player who moves first after start (2'b01 = A, 2'b10 = B).
ALLOW_RESTART, 1, when 1, start is honoured in every state; when 0, start is only honoured in INIT/Awin/Bwin/DRAW.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; clears the board and begins a game.
move_req  input  1  one-cycle pulse; move request, sampled only in WAIT.
move_player  input  2  requesting player (01 = A, 10 = B).
move_cell  input  4  cell index 0..8, row-major.
valid_move  input  1  verdict from check_move.
turn  output  2  player to move (00 when no game is active).
state  output  3  game state: INIT=000, PLAY=001, Awin=010, Bwin=011, DRAW=100.
curr_move  output  18  committed board; [8:0] = A cells, [17:9] = B cells.
next_move  output  18  candidate board presented to the checker.
busy  output  1  high in CHECK and EVAL.
move_ack  output  1  one-cycle pulse when a move is committed.
move_nack  output  1  one-cycle pulse when a move is rejected.
move_count  output  4  number of committed moves, 0..9.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: all outputs registered. On rst: state=INIT, turn=00, curr_move=0, next_move=0, move_count=0, busy=0, move_ack=0, move_nack=0, internal FSM=IDLE.
- Internal FSM states: IDLE, WAIT, CHECK, EVAL, DONE.
- IDLE:
  - state=INIT.
  - On start: curr_move=0, next_move=0, move_count=0, turn=FIRST_PLAYER, state=PLAY, go to WAIT.
- WAIT, when move_req is sampled:
  - Local reject (no checker involvement): move_cell>8, move_player not 01/10, or target bit already set in either half of curr_move. Action: move_nack pulses the next cycle, stay in WAIT, next_move unchanged.
  - Otherwise: next_move <= curr_move | (1 << (move_cell + (move_player==10 ? 9 : 0))), then go to CHECK.
- Player/turn mismatch is not pre-filtered. It is forwarded to the checker, which reports it.
- CHECK (exactly 1 cycle; the checker is combinational on next_move): valid_move is sampled at the end of CHECK.
  - valid_move=1: curr_move <= next_move, move_count += 1, turn toggles 01<->10, move_ack pulses, go to EVAL.
  - valid_move=0: next_move <= curr_move (restore), move_nack pulses, go to WAIT.
- Request latency: move_req in cycle N gives move_ack or move_nack asserted in cycle N+2. A local reject gives move_nack in cycle N+1.
- EVAL (1 cycle) on curr_move:
  - Winning lines: rows {0,1,2}, {3,4,5}, {6,7,8}; columns {0,3,6}, {1,4,7}, {2,5,8}; diagonals {0,4,8}, {2,4,6}. Lines are checked per half.
  - A line complete -> state=Awin. B line complete -> state=Bwin. Either case: turn=00, go to DONE.
  - A and B both complete is impossible by construction; if it ever occurs, A takes priority.
  - Else move_count==9 -> state=DRAW, turn=00, go to DONE.
  - Else go to WAIT.
  - A win on the 9th move reports the win, not DRAW.
- DONE:
  - state holds Awin/Bwin/DRAW.
  - move_req is ignored; no ack/nack.
  - start behaves as in IDLE.
- start precedence:
  - start in the same cycle as move_req: start wins and the request is dropped.
  - start mid-game (WAIT/CHECK/EVAL) with ALLOW_RESTART=1 aborts any pending move (no ack/nack) and restarts.
- Invariants:
  - move_req outside WAIT: ignored silently.
  - next_move differs from curr_move only during CHECK. This keeps the checker's curr!=next gate closed otherwise.
  - rst asserted in any state returns to reset values on the next edge.

Test Plan:
- rst, start, then A requests cell 4 -> next_move=18'h00010 in CHECK; with valid_move=1, curr_move=18'h00010, turn=10, move_ack at N+2, move_count=1.
- A plays 0, B plays 3, A plays 1, B plays 4, A plays 2, all with valid_move=1 -> state=010 (Awin) one cycle after the 5th ack, turn=00; a further move_req produces no ack/nack.
- Sequence 0A 1B 2A 4B 3A 5B 7A 6B 8A -> no line complete; state=100 (DRAW) after the 9th commit, move_count=9.
- A requests cell 4 twice -> second request gives move_nack at N+1 (local occupied), next_move unchanged. Separately, move_cell=9 -> move_nack at N+1.
- Checker returns valid_move=0 (B requests on A's turn) -> move_nack at N+2, next_move restored to curr_move, turn unchanged, move_count unchanged.
- start asserted in the same cycle as move_req mid-game -> board cleared, turn=FIRST_PLAYER, no ack/nack. Then rst asserted during CHECK -> state=000 and all outputs at reset values on the next edge.

Source files
------------

// File: rtl/game_controller.sv
// Tic-tac-toe game controller. It holds the committed board and the game state,
// turns move requests into candidate boards for an external combinational move
// checker, commits or rejects each move from the checker's verdict, then
// evaluates win/draw.
//
// Handshake: move_req is a one-cycle pulse, accepted only while the internal
// FSM is in WAIT. Every accepted request produces exactly one move_ack or
// move_nack pulse: one cycle later for a local reject, two cycles later for a
// checker verdict. A request made in any other phase is dropped without a
// response. start takes precedence over move_req in the same cycle.
module game_controller #(
    parameter logic [1:0] FIRST_PLAYER  = 2'b01,
    parameter bit         ALLOW_RESTART = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_req,
    input  logic [1:0]  move_player,
    input  logic [3:0]  move_cell,
    input  logic        valid_move,
    output logic [1:0]  turn,
    output logic [2:0]  state,
    output logic [17:0] curr_move,
    output logic [17:0] next_move,
    output logic        busy,
    output logic        move_ack,
    output logic        move_nack,
    output logic [3:0]  move_count,
    output logic [2:0]  fsm_state
);

    localparam logic [2:0] ST_INIT = 3'b000;
    localparam logic [2:0] ST_PLAY = 3'b001;
    localparam logic [2:0] ST_AWIN = 3'b010;
    localparam logic [2:0] ST_BWIN = 3'b011;
    localparam logic [2:0] ST_DRAW = 3'b100;

    localparam logic [1:0] PLAYER_A = 2'b01;
    localparam logic [1:0] PLAYER_B = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        CHECK = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } fsm_t;

    fsm_t fsm;

    logic [8:0]  cell_onehot;
    logic [17:0] cand_mask;
    logic        local_reject;
    logic        start_ok;
    logic        a_line;
    logic        b_line;

    // True when any of the eight winning lines is fully occupied in one half.
    function automatic logic has_line(input logic [8:0] c);
        logic r;
        r = ((c & 9'h007) == 9'h007) |   // row 0,1,2
            ((c & 9'h038) == 9'h038) |   // row 3,4,5
            ((c & 9'h1C0) == 9'h1C0) |   // row 6,7,8
            ((c & 9'h049) == 9'h049) |   // col 0,3,6
            ((c & 9'h092) == 9'h092) |   // col 1,4,7
            ((c & 9'h124) == 9'h124) |   // col 2,5,8
            ((c & 9'h111) == 9'h111) |   // diag 0,4,8
            ((c & 9'h054) == 9'h054);    // diag 2,4,6
        return r;
    endfunction

    // Request decode: target cell mask and the checks that need no checker.
    always_comb begin
        cell_onehot  = 9'd1 << move_cell;   // zero when move_cell > 8
        cand_mask    = (move_player == PLAYER_B) ? {cell_onehot, 9'b0} : {9'b0, cell_onehot};
        local_reject = (move_cell > 4'd8)
                     || ((move_player != PLAYER_A) && (move_player != PLAYER_B))
                     || (((curr_move[8:0] | curr_move[17:9]) & cell_onehot) != 9'b0);
        start_ok     = start && ((fsm == IDLE) || (fsm == DONE) || ALLOW_RESTART);
        a_line       = has_line(curr_move[8:0]);
        b_line       = has_line(curr_move[17:9]);
        fsm_state    = fsm;
    end

    // Game FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            state      <= ST_INIT;
            turn       <= 2'b00;
            curr_move  <= 18'b0;
            next_move  <= 18'b0;
            move_count <= 4'd0;
            busy       <= 1'b0;
            move_ack   <= 1'b0;
            move_nack  <= 1'b0;
        end else begin
            move_ack  <= 1'b0;
            move_nack <= 1'b0;
            if (start_ok) begin
                // Fresh game; any in-flight move is abandoned without a response.
                fsm        <= WAIT;
                state      <= ST_PLAY;
                turn       <= FIRST_PLAYER;
                curr_move  <= 18'b0;
                next_move  <= 18'b0;
                move_count <= 4'd0;
                busy       <= 1'b0;
            end else begin
                case (fsm)
                    IDLE: begin
                        state <= ST_INIT;
                    end
                    WAIT: begin
                        if (move_req) begin
                            if (local_reject) begin
                                move_nack <= 1'b1;
                            end else begin
                                next_move <= curr_move | cand_mask;
                                busy      <= 1'b1;
                                fsm       <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (valid_move) begin
                            curr_move  <= next_move;
                            move_count <= move_count + 4'd1;
                            turn       <= (turn == PLAYER_A) ? PLAYER_B : PLAYER_A;
                            move_ack   <= 1'b1;
                            fsm        <= EVAL;
                        end else begin
                            // Restore so the checker sees curr == next again.
                            next_move <= curr_move;
                            move_nack <= 1'b1;
                            busy      <= 1'b0;
                            fsm       <= WAIT;
                        end
                    end
                    EVAL: begin
                        busy <= 1'b0;
                        if (a_line) begin
                            state <= ST_AWIN;
                            turn  <= 2'b00;
                            fsm   <= DONE;
                        end else if (b_line) begin
                            state <= ST_BWIN;
                            turn  <= 2'b00;
                            fsm   <= DONE;
                        end else if (move_count == 4'd9) begin
                            state <= ST_DRAW;
                            turn  <= 2'b00;
                            fsm   <= DONE;
                        end else begin
                            fsm <= WAIT;
                        end
                    end
                    DONE: begin
                        fsm <= DONE;
                    end
                    default: begin
                        fsm <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
